// File: rtl/msg_pkg.sv
// Shared types for the message unpacker: parser states and header field widths.
package msg_pkg;

  localparam int BYTE_W  = 8;
  localparam int FIELD_W = 16;

  typedef logic [FIELD_W-1:0] len_t;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    DRAIN
  } state_t;

endpackage

// File: rtl/msg_beat_buf.sv
// One-beat AXI-ST buffer that hands the parser one kept byte per clock,
// flagging the packet's final byte and the beat's tuser.
module msg_beat_buf
  import msg_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [BYTE_W*DATA_BYTES-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]       s_tkeep,
  input  logic                        s_tlast,
  input  logic                        s_tuser,
  output logic                        byte_vld,
  output logic [BYTE_W-1:0]           byte_data,
  output logic                        byte_last,
  output logic                        byte_user
);

  localparam int PTR_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic [BYTE_W*DATA_BYTES-1:0] data_q, data_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [PTR_W-1:0]             end_q, end_d;
  logic                         vld_q, vld_d;
  logic                         last_q, last_d;
  logic                         user_q, user_d;
  logic [PTR_W-1:0]             keep_end;
  logic                         at_end;
  logic                         load;

  // tkeep is contiguous from bit 0, so the highest set bit marks the final kept byte.
  always_comb begin
    keep_end = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_tkeep[i]) keep_end = PTR_W'(i);
    end
  end

  assign at_end   = (ptr_q == end_q);
  assign s_tready = ~rst & (~vld_q | at_end);
  assign load     = s_tvalid & s_tready;

  always_comb begin
    data_d = data_q;
    ptr_d  = ptr_q;
    end_d  = end_q;
    vld_d  = vld_q;
    last_d = last_q;
    user_d = user_q;
    if (load) begin
      data_d = s_tdata;
      ptr_d  = '0;
      end_d  = keep_end;
      vld_d  = 1'b1;
      last_d = s_tlast;
      user_d = s_tuser;
    end else if (vld_q) begin
      if (at_end) vld_d = 1'b0;
      else        ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ptr_q  <= '0;
      end_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      user_q <= 1'b0;
    end else begin
      data_q <= data_d;
      ptr_q  <= ptr_d;
      end_q  <= end_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      user_q <= user_d;
    end
  end

  assign byte_vld  = vld_q;
  assign byte_data = data_q[BYTE_W*ptr_q +: BYTE_W];
  assign byte_last = last_q & at_end;
  assign byte_user = user_q;

endmodule

// File: rtl/msg_unpacker.sv
// Splits length-prefixed messages out of AXI-ST packets, one byte per clock,
// reporting each message (or one error per packet) as a single-cycle pulse.
module msg_unpacker
  import msg_pkg::*;
#(
  parameter int DATA_BYTES    = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic [8*DATA_BYTES-1:0]         s_tdata,
  input  logic [DATA_BYTES-1:0]           s_tkeep,
  input  logic                            s_tlast,
  input  logic                            s_tuser,
  output logic                            msg_valid,
  output logic [15:0]                     msg_length,
  output logic [8*MAX_MSG_BYTES-1:0]      msg_data,
  output logic                            msg_error,
  output logic                            pkt_done,
  output logic [15:0]                     err_cnt
);

  logic              byte_vld, byte_last, byte_user;
  logic [BYTE_W-1:0] byte_data;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [BYTE_W-1:0] len_hi_q, len_hi_d;
  len_t              msgs_left_q, msgs_left_d;
  len_t              len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic              err_sent_q, err_sent_d;
  logic              pend_q, pend_d;
  logic [BYTE_W-1:0] work_q [MAX_MSG_BYTES];
  logic [BYTE_W-1:0] work_d [MAX_MSG_BYTES];
  logic [8*MAX_MSG_BYTES-1:0] work_flat;

  logic                       msg_valid_q, msg_valid_d;
  logic                       msg_error_q, msg_error_d;
  logic                       pkt_done_q, pkt_done_d;
  len_t                       msg_length_q, msg_length_d;
  len_t                       err_cnt_q, err_cnt_d;
  logic [8*MAX_MSG_BYTES-1:0] msg_data_q, msg_data_d;

  logic emit, emit_err, emit_pay, done, pend_set;
  len_t emit_len, cur_cnt, cur_len, idx_next;

  msg_beat_buf #(.DATA_BYTES(DATA_BYTES)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .byte_last (byte_last),
    .byte_user (byte_user)
  );

  assign cur_cnt  = {cnt_hi_q, byte_data};
  assign cur_len  = {len_hi_q, byte_data};
  assign idx_next = len_t'(idx_q) + len_t'(1);

  // Working payload is cleared while the length arrives so unused bytes read back as zero.
  always_comb begin
    for (int i = 0; i < MAX_MSG_BYTES; i++) begin
      work_d[i] = work_q[i];
      if (byte_vld && state_q == LEN_LO)
        work_d[i] = '0;
      else if (byte_vld && state_q == PAYLOAD && idx_q == 8'(i))
        work_d[i] = byte_data;
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_MSG_BYTES; gi++) begin : g_flat
      assign work_flat[8*gi +: 8] = work_d[gi];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_hi_d    = cnt_hi_q;
    len_hi_d    = len_hi_q;
    msgs_left_d = msgs_left_q;
    len_d       = len_q;
    idx_d       = idx_q;
    err_sent_d  = err_sent_q;
    emit        = 1'b0;
    emit_err    = 1'b0;
    emit_pay    = 1'b0;
    emit_len    = '0;
    done        = 1'b0;
    pend_set    = 1'b0;

    if (byte_vld) begin
      unique case (state_q)
        CNT_HI: begin
          cnt_hi_d = byte_data;
          if (byte_last) begin
            emit = 1'b1; emit_err = 1'b1; done = 1'b1;
          end else begin
            state_d = CNT_LO;
          end
        end
        CNT_LO: begin
          if (byte_last) begin
            done    = 1'b1;
            state_d = CNT_HI;
            if (cur_cnt != '0 || byte_user) begin
              emit = 1'b1; emit_err = 1'b1;
            end
          end else if (cur_cnt == '0) begin
            emit = 1'b1; emit_err = 1'b1; err_sent_d = 1'b1;
            state_d = DRAIN;
          end else begin
            msgs_left_d = cur_cnt;
            state_d     = LEN_HI;
          end
        end
        LEN_HI: begin
          len_hi_d = byte_data;
          if (byte_last) begin
            emit = 1'b1; emit_err = 1'b1; done = 1'b1;
            state_d = CNT_HI;
          end else begin
            state_d = LEN_LO;
          end
        end
        LEN_LO: begin
          if (byte_last) begin
            emit = 1'b1; emit_err = 1'b1; done = 1'b1;
            state_d = CNT_HI;
          end else if (cur_len < len_t'(MIN_MSG_BYTES) || cur_len > len_t'(MAX_MSG_BYTES)) begin
            emit = 1'b1; emit_err = 1'b1; emit_len = cur_len; err_sent_d = 1'b1;
            state_d = DRAIN;
          end else begin
            len_d   = cur_len;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (idx_next == len_q) begin
            emit        = 1'b1;
            emit_pay    = 1'b1;
            emit_len    = len_q;
            msgs_left_d = msgs_left_q - len_t'(1);
            if (byte_last) begin
              state_d = CNT_HI;
              if (byte_user) begin
                emit_err = 1'b1; done = 1'b1;
              end else if (msgs_left_q != len_t'(1)) begin
                // Good message occupies this slot; the truncation error follows next cycle.
                pend_set = 1'b1;
              end else begin
                done = 1'b1;
              end
            end else if (msgs_left_q == len_t'(1)) begin
              state_d = DRAIN;
            end else begin
              state_d = LEN_HI;
            end
          end else if (byte_last) begin
            emit = 1'b1; emit_err = 1'b1; emit_len = idx_next; done = 1'b1;
            state_d = CNT_HI;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
        DRAIN: begin
          if (!err_sent_q) begin
            emit = 1'b1; emit_err = 1'b1; err_sent_d = 1'b1;
          end
          if (byte_last) begin
            done    = 1'b1;
            state_d = CNT_HI;
          end
        end
        default: state_d = CNT_HI;
      endcase
    end

    if (state_d == CNT_HI) err_sent_d = 1'b0;
  end

  always_comb begin
    msg_valid_d  = 1'b0;
    msg_error_d  = 1'b0;
    msg_length_d = msg_length_q;
    msg_data_d   = msg_data_q;
    pkt_done_d   = 1'b0;
    pend_d       = pend_set;
    if (pend_q) begin
      msg_valid_d  = 1'b1;
      msg_error_d  = 1'b1;
      msg_length_d = '0;
      msg_data_d   = '0;
      pkt_done_d   = 1'b1;
      if (emit) pend_d = 1'b1;
    end else begin
      pkt_done_d = done;
      if (emit) begin
        msg_valid_d  = 1'b1;
        msg_error_d  = emit_err;
        msg_length_d = emit_len;
        msg_data_d   = emit_pay ? work_flat : '0;
      end
    end
    err_cnt_d = err_cnt_q;
    if (msg_valid_d && msg_error_d && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CNT_HI;
      cnt_hi_q     <= '0;
      len_hi_q     <= '0;
      msgs_left_q  <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      err_sent_q   <= 1'b0;
      pend_q       <= 1'b0;
      for (int i = 0; i < MAX_MSG_BYTES; i++) work_q[i] <= '0;
      msg_valid_q  <= 1'b0;
      msg_error_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      msg_length_q <= '0;
      msg_data_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_hi_q     <= cnt_hi_d;
      len_hi_q     <= len_hi_d;
      msgs_left_q  <= msgs_left_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      err_sent_q   <= err_sent_d;
      pend_q       <= pend_d;
      for (int i = 0; i < MAX_MSG_BYTES; i++) work_q[i] <= work_d[i];
      msg_valid_q  <= msg_valid_d;
      msg_error_q  <= msg_error_d;
      pkt_done_q   <= pkt_done_d;
      msg_length_q <= msg_length_d;
      msg_data_q   <= msg_data_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_error  = msg_error_q;
  assign pkt_done   = pkt_done_q;
  assign msg_length = msg_length_q;
  assign msg_data   = msg_data_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_msg_unpacker.sv
// Scoreboard bench: an 8-byte-beat unpacker driven gapless and a 4-byte-beat one driven with random gaps.
module tb_msg_unpacker;

  typedef struct {
    bit           mv;
    bit           err;
    logic [15:0]  len;
    logic [255:0] data;
    bit           done;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  logic         a_tvalid, a_tready, a_tlast, a_tuser;
  logic [63:0]  a_tdata;
  logic [7:0]   a_tkeep;
  logic         a_msg_valid, a_msg_error, a_pkt_done;
  logic [15:0]  a_msg_length, a_err_cnt;
  logic [255:0] a_msg_data;

  logic         b_tvalid, b_tready, b_tlast, b_tuser;
  logic [31:0]  b_tdata;
  logic [3:0]   b_tkeep;
  logic         b_msg_valid, b_msg_error, b_pkt_done;
  logic [15:0]  b_msg_length, b_err_cnt;
  logic [255:0] b_msg_data;

  ev_t        qa[$];
  ev_t        qb[$];
  logic [7:0] pkt[$];
  int checks = 0;
  int errors = 0;
  int exp_ecnt_a = 0;
  int exp_ecnt_b = 0;

  always #5 clk = ~clk;

  msg_unpacker #(.DATA_BYTES(8), .MAX_MSG_BYTES(32), .MIN_MSG_BYTES(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_tvalid(a_tvalid), .s_tready(a_tready), .s_tdata(a_tdata), .s_tkeep(a_tkeep),
    .s_tlast(a_tlast), .s_tuser(a_tuser),
    .msg_valid(a_msg_valid), .msg_length(a_msg_length), .msg_data(a_msg_data),
    .msg_error(a_msg_error), .pkt_done(a_pkt_done), .err_cnt(a_err_cnt)
  );

  msg_unpacker #(.DATA_BYTES(4), .MAX_MSG_BYTES(32), .MIN_MSG_BYTES(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tdata(b_tdata), .s_tkeep(b_tkeep),
    .s_tlast(b_tlast), .s_tuser(b_tuser),
    .msg_valid(b_msg_valid), .msg_length(b_msg_length), .msg_data(b_msg_data),
    .msg_error(b_msg_error), .pkt_done(b_pkt_done), .err_cnt(b_err_cnt)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int len, input int base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[8*i +: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic put16(input int v);
    pkt.push_back(8'(v >> 8));
    pkt.push_back(8'(v));
  endtask

  task automatic put_pay(input int len, input int base);
    for (int i = 0; i < len; i++) pkt.push_back(8'(base + i));
  endtask

  task automatic ev(input int which, input bit mv, input bit err, input int len,
                    input logic [255:0] data, input bit done);
    ev_t e;
    e.mv = mv; e.err = err; e.len = 16'(len); e.data = data; e.done = done;
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  task automatic compare(input string tag, input ev_t e, input logic mv, input logic err,
                         input logic [15:0] len, input logic [255:0] data, input logic done,
                         input logic [15:0] ecnt, input int exp_ecnt);
    $display("%s event: valid=%0b error=%0b length=%0d done=%0b err_cnt=%0d",
             tag, mv, err, len, done, ecnt);
    chk({tag, "_msg_valid"}, 256'(mv), 256'(e.mv));
    chk({tag, "_pkt_done"}, 256'(done), 256'(e.done));
    if (e.mv) begin
      chk({tag, "_msg_error"}, 256'(err), 256'(e.err));
      chk({tag, "_msg_length"}, 256'(len), 256'(e.len));
      chk({tag, "_msg_data"}, data, e.data);
    end
    chk({tag, "_err_cnt"}, 256'(ecnt), 256'(exp_ecnt));
  endtask

  ev_t ea, eb;

  always @(negedge clk) begin
    if (a_msg_valid || a_pkt_done) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected valid=%0b done=%0b length=%0d required=no_event",
                 a_msg_valid, a_pkt_done, a_msg_length);
      end else begin
        ea = qa.pop_front();
        if (ea.mv && ea.err) exp_ecnt_a++;
        compare("a", ea, a_msg_valid, a_msg_error, a_msg_length, a_msg_data, a_pkt_done,
                a_err_cnt, exp_ecnt_a);
      end
    end
  end

  always @(negedge clk) begin
    if (b_msg_valid || b_pkt_done) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected valid=%0b done=%0b length=%0d required=no_event",
                 b_msg_valid, b_pkt_done, b_msg_length);
      end else begin
        eb = qb.pop_front();
        if (eb.mv && eb.err) exp_ecnt_b++;
        compare("b", eb, b_msg_valid, b_msg_error, b_msg_length, b_msg_data, b_pkt_done,
                b_err_cnt, exp_ecnt_b);
      end
    end
  end

  // Sends the bytes in pkt as beats of the chosen DUT's width; stops early after max_beats.
  task automatic send(input int which, input bit user, input int gap_max, input int max_beats);
    int db, n, pos, beats, cnt, t;
    logic [63:0] d;
    logic [7:0]  k;
    bit last;
    db = (which == 0) ? 8 : 4;
    n = pkt.size(); pos = 0; beats = 0;
    while (pos < n && beats < max_beats) begin
      if (gap_max > 0) begin
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk); #1;
        end
      end
      d = '0; k = '0;
      cnt = (n - pos < db) ? (n - pos) : db;
      for (int i = 0; i < cnt; i++) begin
        d[8*i +: 8] = pkt[pos + i];
        k[i] = 1'b1;
      end
      pos += cnt; beats++;
      last = (pos == n);
      if (which == 0) begin
        a_tvalid = 1'b1; a_tdata = d; a_tkeep = k; a_tlast = last; a_tuser = user & last;
      end else begin
        b_tvalid = 1'b1; b_tdata = d[31:0]; b_tkeep = k[3:0]; b_tlast = last; b_tuser = user & last;
      end
      t = 0;
      forever begin
        @(negedge clk);
        if ((which == 0) ? a_tready : b_tready) break;
        t++;
        if (t > 500) break;
      end
      if (t > 500) begin
        checks++; errors++;
        $display("FAIL tready_timeout dut=%0d actual=0 required=1", which);
        pos = n;
      end
      @(posedge clk); #1;
    end
    a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (((which == 0) ? qa.size() : qb.size()) != 0 && n < 2000) begin
      @(negedge clk); n++;
    end
    if (((which == 0) ? qa.size() : qb.size()) != 0) begin
      checks++; errors++;
      $display("FAIL event_timeout dut=%0d pending=%0d required=0", which,
               (which == 0) ? qa.size() : qb.size());
      if (which == 0) qa.delete(); else qb.delete();
    end
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // count=2, lengths 8 and 10, 24 bytes
  task automatic t_two_msgs(input int which, input int gap);
    pkt.delete(); put16(2); put16(8); put_pay(8, 'h10); put16(10); put_pay(10, 'h40);
    ev(which, 1, 0, 8, pat(8, 'h10), 0);
    ev(which, 1, 0, 10, pat(10, 'h40), 1);
    send(which, 0, gap, 1000); wait_idle(which);
  endtask

  // count=1, length 16: 20 bytes so the final 8-byte beat has tkeep=0x0F
  task automatic t_partial_keep(input int which, input int gap);
    pkt.delete(); put16(1); put16(16); put_pay(16, 'hA0);
    ev(which, 1, 0, 16, pat(16, 'hA0), 1);
    send(which, 0, gap, 1000); wait_idle(which);
  endtask

  task automatic t_len_too_big(input int which, input int gap);
    pkt.delete(); put16(1); put16(40); put_pay(10, 'h55);
    ev(which, 1, 1, 40, '0, 0);
    ev(which, 0, 0, 0, '0, 1);
    send(which, 0, gap, 1000); wait_idle(which);
  endtask

  task automatic t_short_count(input int which, input int gap);
    pkt.delete(); put16(3); put16(8); put_pay(8, 'h01); put16(9); put_pay(9, 'h80);
    ev(which, 1, 0, 8, pat(8, 'h01), 0);
    ev(which, 1, 0, 9, pat(9, 'h80), 0);
    ev(which, 1, 1, 0, '0, 1);
    send(which, 0, gap, 1000); wait_idle(which);
  endtask

  task automatic t_zero_count(input int which, input bit user);
    pkt.delete(); put16(0);
    if (user) ev(which, 1, 1, 0, '0, 1);
    else      ev(which, 0, 0, 0, '0, 1);
    send(which, user, 0, 1000); wait_idle(which);
  endtask

  task automatic t_extra_bytes(input int which, input int gap);
    pkt.delete(); put16(1); put16(8); put_pay(8, 'hC0); put_pay(3, 'hEE);
    ev(which, 1, 0, 8, pat(8, 'hC0), 0);
    ev(which, 1, 1, 0, '0, 0);
    ev(which, 0, 0, 0, '0, 1);
    send(which, 0, gap, 1000); wait_idle(which);
  endtask

  task automatic t_trunc_payload(input int which);
    pkt.delete(); put16(1); put16(12); put_pay(5, 'h30);
    ev(which, 1, 1, 5, '0, 1);
    send(which, 0, 0, 1000); wait_idle(which);
  endtask

  task automatic t_user_on_msg(input int which);
    pkt.delete(); put16(1); put16(8); put_pay(8, 'h70);
    ev(which, 1, 1, 8, pat(8, 'h70), 1);
    send(which, 1, 0, 1000); wait_idle(which);
  endtask

  task automatic t_len_bounds(input int which, input int gap);
    pkt.delete(); put16(2); put16(32); put_pay(32, 'h00); put16(7); put_pay(7, 'h90);
    ev(which, 1, 0, 32, pat(32, 'h00), 0);
    ev(which, 1, 1, 7, '0, 0);
    ev(which, 0, 0, 0, '0, 1);
    send(which, 0, gap, 1000); wait_idle(which);
  endtask

  initial begin
    rst = 1'b1;
    a_tvalid = 1'b0; a_tdata = '0; a_tkeep = '0; a_tlast = 1'b0; a_tuser = 1'b0;
    b_tvalid = 1'b0; b_tdata = '0; b_tkeep = '0; b_tlast = 1'b0; b_tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 256'(a_tready), 256'(0));
    chk("rst_msg_valid", 256'(a_msg_valid), 256'(0));
    chk("rst_pkt_done", 256'(a_pkt_done), 256'(0));
    chk("rst_msg_error", 256'(a_msg_error), 256'(0));
    chk("rst_msg_length", 256'(a_msg_length), 256'(0));
    chk("rst_msg_data", a_msg_data, 256'(0));
    chk("rst_err_cnt", 256'(a_err_cnt), 256'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready_a", 256'(a_tready), 256'(1));
    chk("post_rst_tready_b", 256'(b_tready), 256'(1));
    @(posedge clk); #1;

    t_two_msgs(0, 0);
    t_partial_keep(0, 0);
    t_len_too_big(0, 0);
    t_short_count(0, 0);
    t_zero_count(0, 1);
    t_zero_count(0, 0);
    t_extra_bytes(0, 0);
    t_trunc_payload(0);
    t_user_on_msg(0);
    t_len_bounds(0, 0);

    // Abort a packet mid-payload with reset; nothing may be reported for it.
    pkt.delete(); put16(1); put16(16); put_pay(16, 'h22);
    send(0, 0, 0, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_ecnt_a = 0;
    @(negedge clk);
    chk("abort_err_cnt", 256'(a_err_cnt), 256'(0));
    chk("abort_tready", 256'(a_tready), 256'(1));
    @(posedge clk); #1;
    t_two_msgs(0, 0);

    // Narrow beats with random valid gaps must produce the same results.
    t_two_msgs(1, 3);
    t_partial_keep(1, 3);
    t_short_count(1, 3);
    t_len_too_big(1, 3);
    t_extra_bytes(1, 3);
    t_len_bounds(1, 3);
    t_zero_count(1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
